// File: rtl/seg_display_mux_if.sv
// Display-side bundle for seg_display_mux: data/control in, segment and anode drive out.
// The dp_in/dp signals exist only when SEG_DP_EN is defined.
interface seg_display_mux_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [4*NUM_DIGITS-1:0] data;
    logic                    load;
    logic                    blank_lz;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   an;
    logic [IDX_W-1:0]        digit_idx;
    logic                    frame_done;
`ifdef SEG_DP_EN
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    dp;

    modport master (
        output data, load, blank_lz, dp_in,
        input  seg, an, digit_idx, frame_done, dp
    );
    modport slave (
        input  data, load, blank_lz, dp_in,
        output seg, an, digit_idx, frame_done, dp
    );
`else
    modport master (
        output data, load, blank_lz,
        input  seg, an, digit_idx, frame_done
    );
    modport slave (
        input  data, load, blank_lz,
        output seg, an, digit_idx, frame_done
    );
`endif
endinterface

// File: rtl/seg_display_mux.sv
// Time-multiplexed common-anode 7-segment driver with guard slots, leading-zero blanking
// and frame-synchronous data update. Define SEG_DP_EN to add per-digit decimal points.
module seg_display_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 20000,
    parameter int GUARD       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    seg_display_mux_if.slave bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_pending;
    logic [4*NUM_DIGITS-1:0] r_display;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [IDX_W-1:0]        r_digit_idx;
    logic                    r_frame_done;

    logic [3:0]              w_nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   w_nz;
    logic [NUM_DIGITS-1:0]   w_blank;
    logic [NUM_DIGITS-1:0]   w_an_sel;
    logic [NUM_DIGITS-1:0]   w_dp_set;
    logic                    w_slot_end;
    logic                    w_wrap;
    logic                    w_guard;

`ifdef SEG_DP_EN
    logic [NUM_DIGITS-1:0]   r_pending_dp;
    logic [NUM_DIGITS-1:0]   r_display_dp;
    logic                    r_dp;
    assign w_dp_set = r_display_dp;
    assign bus.dp   = r_dp;
`else
    assign w_dp_set = '0;
`endif

    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        case (nib)
            4'h0: f_decode = 7'h40;  4'h1: f_decode = 7'h79;
            4'h2: f_decode = 7'h24;  4'h3: f_decode = 7'h30;
            4'h4: f_decode = 7'h19;  4'h5: f_decode = 7'h12;
            4'h6: f_decode = 7'h02;  4'h7: f_decode = 7'h78;
            4'h8: f_decode = 7'h00;  4'h9: f_decode = 7'h18;
            4'hA: f_decode = 7'h08;  4'hB: f_decode = 7'h03;
            4'hC: f_decode = 7'h46;  4'hD: f_decode = 7'h21;
            4'hE: f_decode = 7'h04;  default: f_decode = 7'h0E;
        endcase
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign w_nib[gi]    = r_display[4*gi +: 4];
            // A set decimal point counts as significant, ending the leading-zero run.
            assign w_nz[gi]     = (|w_nib[gi]) | w_dp_set[gi];
            assign w_an_sel[gi] = (r_idx != IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        logic w_lead;
        w_blank = '0;
        w_lead  = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_lead     = w_lead & ~w_nz[k];
            w_blank[k] = (k != 0) && bus.blank_lz && w_lead;
        end
    end

    assign w_slot_end = (r_cnt == CNT_W'(REFRESH_DIV - 1));
    assign w_wrap     = w_slot_end && (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_guard    = (r_cnt < CNT_W'(GUARD));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_pending    <= '0;
            r_display    <= '0;
            r_seg        <= 7'h7F;
            r_an         <= '1;
            r_digit_idx  <= '0;
            r_frame_done <= 1'b0;
`ifdef SEG_DP_EN
            r_pending_dp <= '0;
            r_display_dp <= '0;
            r_dp         <= 1'b1;
`endif
        end else begin
            if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= w_wrap ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (bus.load) r_pending <= bus.data;
            // A load coinciding with the wrap bypasses pending so it shows this frame.
            if (w_wrap)   r_display <= bus.load ? bus.data : r_pending;
`ifdef SEG_DP_EN
            if (bus.load) r_pending_dp <= bus.dp_in;
            if (w_wrap)   r_display_dp <= bus.load ? bus.dp_in : r_pending_dp;
            r_dp <= w_guard ? 1'b1 : ~r_display_dp[r_idx];
`endif

            r_frame_done <= w_wrap;
            r_digit_idx  <= r_idx;
            if (w_guard || w_blank[r_idx]) begin
                r_an  <= '1;
                r_seg <= 7'h7F;
            end else begin
                r_an  <= w_an_sel;
                r_seg <= f_decode(w_nib[r_idx]);
            end
        end
    end

    assign bus.seg        = r_seg;
    assign bus.an         = r_an;
    assign bus.digit_idx  = r_digit_idx;
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux (4 digits, 8-cycle slots, 2-cycle guard); covers the
// SEG_DP_EN decimal-point path when that macro is defined.
module tb_seg_display_mux;
    localparam int N  = 4;
    localparam int RD = 8;
    localparam int G  = 2;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    seg_display_mux_if #(.NUM_DIGITS(N)) bus();

    seg_display_mux #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .GUARD(G)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int         n_vec   = 0;
    int         n_err   = 0;
    int         n_frame = 0;
    logic [6:0] e_seg [4];
    logic [3:0] e_blank;
    logic [3:0] e_dc;
    logic [3:0] e_dp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] obs();
`ifdef SEG_DP_EN
        return 32'({bus.dp, bus.an, bus.seg, bus.digit_idx, bus.frame_done});
`else
        return 32'({bus.an, bus.seg, bus.digit_idx, bus.frame_done});
`endif
    endfunction

    function automatic logic [31:0] pack(input logic dp, input logic [3:0] an,
                                         input logic [6:0] seg, input logic [1:0] idx,
                                         input logic fd);
`ifdef SEG_DP_EN
        return 32'({dp, an, seg, idx, fd});
`else
        return 32'({an, seg, idx, fd});
`endif
    endfunction

    // Starts with the DUT at cnt=0/idx=0; step j's outputs reflect state j-1 of the frame.
    task automatic check_frame(input int ld_step, input logic [15:0] ld_val, input logic [3:0] ld_dp);
        for (int j = 1; j <= 32; j++) begin
            int         k;
            int         c;
            logic       off;
            logic [3:0] an_e;
            logic [6:0] seg_e;
            logic       dp_e;
            if (j == ld_step) begin
                bus.data = ld_val;
                bus.load = 1'b1;
`ifdef SEG_DP_EN
                bus.dp_in = ld_dp;
`endif
            end
            step();
            bus.load = 1'b0;
            k     = (j - 1) / 8;
            c     = (j - 1) % 8;
            off   = (c < G) || e_blank[k];
            an_e  = off ? 4'hF : ~(4'b0001 << k);
            seg_e = off ? 7'h7F : e_seg[k];
            dp_e  = (c < G) ? 1'b1 : ~e_dp[k];
            if (!e_dc[k])
                chk($sformatf("scan f%0d d%0d c%0d", n_frame, k, c), obs(),
                    pack(dp_e, an_e, seg_e, 2'(k), j == 32));
        end
        $display("frame %0d checked, miscompares so far %0d", n_frame, n_err);
        n_frame++;
    endtask

    initial begin
        bit got_fd;
        reset_n      = 1'b0;
        bus.data     = '0;
        bus.load     = 1'b0;
        bus.blank_lz = 1'b0;
`ifdef SEG_DP_EN
        bus.dp_in    = '0;
`endif
        e_blank = '0;
        e_dc    = '0;
        e_dp    = '0;
        step();
        step();
        chk("reset", obs(), pack(1'b1, 4'hF, 7'h7F, 2'd0, 1'b0));

        reset_n  = 1'b1;
        bus.data = 16'h1234;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        got_fd = 1'b0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (bus.frame_done) begin
                got_fd = 1'b1;
                break;
            end
        end
        chk("first_frame_done", 32'(got_fd), 32'd1);

        e_seg = '{7'h19, 7'h30, 7'h24, 7'h79};
        check_frame(0, 16'h0, 4'h0);
        check_frame(0, 16'h0, 4'h0);
        check_frame(12, 16'hAAAA, 4'h0);

        e_seg = '{7'h08, 7'h08, 7'h08, 7'h08};
        check_frame(32, 16'h00F0, 4'h0);

        e_seg = '{7'h40, 7'h0E, 7'h40, 7'h40};
        check_frame(32, 16'h0050, 4'h0);

        bus.blank_lz = 1'b1;
        e_seg   = '{7'h40, 7'h12, 7'h7F, 7'h7F};
        e_blank = 4'b1100;
        check_frame(32, 16'h0000, 4'h0);

        e_seg   = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
        e_blank = 4'b1110;
        check_frame(32, 16'h1234, 4'h0);

        bus.blank_lz = 1'b0;
        e_blank = '0;
        for (int i = 0; i < 21; i++) step();
        chk("pre_reset", obs(), pack(1'b1, 4'hB, 7'h24, 2'd2, 1'b0));
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_reset", obs(), pack(1'b1, 4'hF, 7'h7F, 2'd0, 1'b0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        e_seg = '{7'h40, 7'h40, 7'h40, 7'h40};
        check_frame(32, 16'h0007, 4'b0100);

        bus.blank_lz = 1'b1;
`ifdef SEG_DP_EN
        e_seg   = '{7'h78, 7'h7F, 7'h40, 7'h7F};
        e_blank = 4'b1000;
        e_dc    = 4'b0010;
        e_dp    = 4'b0100;
`else
        e_seg   = '{7'h78, 7'h7F, 7'h7F, 7'h7F};
        e_blank = 4'b1110;
`endif
        check_frame(0, 16'h0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
